serial_mag_comparator: RTL and testbench

Multi-word unsigned magnitude comparator. It compares two wide operands one 4-bit nibble per clock, starting at the most significant nibble, using a zero-delay combinational nibble compare. Scanning stops at the first nibble that differs. It sits between the operand registers and any control logic that needs a registered gt/eq/lt verdict on words wider than 4 bits, with a start/done handshake.

---
 rtl/serial_mag_comparator_pkg.sv | 11 +
 rtl/serial_mag_comparator_nibble_cmp.sv | 12 +
 rtl/serial_mag_comparator.sv | 74 +++++++
 tb/tb_serial_mag_comparator.sv | 112 +++++++++++
 4 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// serial_mag_comparator_pkg: shared state encodings and parameter limits.
package serial_mag_comparator_pkg;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;
   localparam int NIBBLES_MIN = 1;
   localparam int NIBBLES_MAX = 16;

   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction
endpackage

// File: rtl/serial_mag_comparator_nibble_cmp.sv
// nibble_cmp: combinational 4-bit unsigned magnitude compare.
module nibble_cmp (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       n_gt,
   output logic       n_eq,
   output logic       n_lt
);
   assign n_gt = a > b;
   assign n_eq = a == b;
   assign n_lt = a < b;
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first nibble-serial unsigned compare with start/done handshake.
module serial_mag_comparator
   import serial_mag_comparator_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] data_a,
   input  logic [4*NIBBLES-1:0] data_b,
   output logic                 busy,
   output logic                 done,
   output logic                 gt,
   output logic                 eq,
   output logic                 lt
);
   localparam int W  = 4*NIBBLES;
   localparam int IW = idx_width(NIBBLES);

   if (NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX) begin : g_range
      $error("serial_mag_comparator: NIBBLES out of range");
   end

   logic [0:0]    state;
   logic [W-1:0]  op_a, op_b;
   logic [IW-1:0] idx;
   logic          n_gt, n_eq, n_lt;

   nibble_cmp u_cmp (
      .a    (op_a[4*idx +: 4]),
      .b    (op_b[4*idx +: 4]),
      .n_gt (n_gt),
      .n_eq (n_eq),
      .n_lt (n_lt)
   );

   assign busy = state == SCAN;

   // Operands and index are don't-care after reset, so only control and results are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               op_a  <= data_a;
               op_b  <= data_b;
               idx   <= IW'(NIBBLES-1);
               state <= SCAN;
            end
         end else if (!n_eq) begin
            gt    <= n_gt;
            lt    <= n_lt;
            eq    <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
         end else if (idx == '0) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
         end else begin
            idx <= idx - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed checks of {busy,done,gt,eq,lt} per cycle, NIBBLES=4.
module tb_serial_mag_comparator;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] data_a, data_b;
   logic        busy, done, gt, eq, lt;
   int          errors = 0;
   int          checks = 0;

   serial_mag_comparator #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .data_a (data_a),
      .data_b (data_b),
      .busy   (busy),
      .done   (done),
      .gt     (gt),
      .eq     (eq),
      .lt     (lt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // exp order: {busy, done, gt, eq, lt}
   task automatic chk(input string tag, input logic [4:0] exp);
      checks++;
      assert ({busy, done, gt, eq, lt} === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, {busy, done, gt, eq, lt}, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; data_a = 16'hFFFF; data_b = 16'h0000;
      step(); chk("reset1", 5'b00000);
      step(); chk("reset2", 5'b00000);
      rst = 1'b0; start = 1'b0;
      step(); chk("post_reset_idle", 5'b00000);

      // Equal operands: four SCAN cycles then eq
      data_a = 16'h1234; data_b = 16'h1234; start = 1'b1;
      step(); start = 1'b0; data_a = 16'hDEAD; data_b = 16'h0001;
      chk("eq_busy1", 5'b10000);
      for (int i = 2; i <= 4; i++) begin step(); chk("eq_busyN", 5'b10000); end
      step(); chk("eq_done", 5'b01010);
      step(); chk("eq_hold", 5'b00010);

      // MSB decides
      data_a = 16'h9000; data_b = 16'h8FFF; start = 1'b1;
      step(); start = 1'b0;
      chk("msb_busy", 5'b10010);
      step(); chk("msb_done", 5'b01100);
      step(); chk("msb_hold", 5'b00100);

      // LSB decides
      data_a = 16'h1234; data_b = 16'h1235; start = 1'b1;
      step(); start = 1'b0;
      chk("lsb_busy1", 5'b10100);
      for (int i = 2; i <= 4; i++) begin step(); chk("lsb_busyN", 5'b10100); end
      step(); chk("lsb_done", 5'b01001);
      step(); chk("lsb_hold", 5'b00001);

      // Zero vs zero: lt held until new done, then eq
      data_a = 16'h0000; data_b = 16'h0000; start = 1'b1;
      step(); start = 1'b0;
      chk("zero_busy1", 5'b10001);
      for (int i = 2; i <= 4; i++) begin step(); chk("zero_busyN", 5'b10001); end
      step(); chk("zero_done", 5'b01010);

      // start mid-scan ignored; start in done cycle accepted
      data_a = 16'h0001; data_b = 16'h0002; start = 1'b1;
      step(); start = 1'b0;
      chk("hs_busy1", 5'b10010);
      step(); chk("hs_busy2", 5'b10010);
      data_a = 16'hF000; data_b = 16'h0000; start = 1'b1;
      step(); start = 1'b0;
      chk("hs_ignored", 5'b10010);
      step(); chk("hs_busy4", 5'b10010);
      step(); chk("hs_done_lt", 5'b01001);
      data_a = 16'hF000; data_b = 16'h0000; start = 1'b1;
      step(); start = 1'b0;
      chk("b2b_accept", 5'b10001);
      step(); chk("b2b_done_gt", 5'b01100);
      step(); chk("b2b_no_queue", 5'b00100);

      // Abort during the 2nd SCAN cycle of an equal compare
      data_a = 16'h5555; data_b = 16'h5555; start = 1'b1;
      step(); start = 1'b0;
      chk("abort_busy1", 5'b10100);
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      chk("abort_cleared", 5'b00000);
      for (int i = 0; i < 6; i++) begin step(); chk("abort_no_done", 5'b00000); end

      // Compare after abort: decided at nibble 2
      data_a = 16'h0100; data_b = 16'h0010; start = 1'b1;
      step(); start = 1'b0;
      chk("mid_busy1", 5'b10000);
      step(); chk("mid_busy2", 5'b10000);
      step(); chk("mid_done_gt", 5'b01100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
